delay_fifo_drain: RTL and testbench
===================================

Name: delay_fifo_drain

Overview:
- Read-side counterpart to the fixed-latency delay registers used in the CNN datapath.
- Accepts a delayed, valid-qualified stream into a small circular buffer.
- Drains the buffer to a consumer with valid/ready backpressure, in fixed-length bursts or as a full flush on request.
- Sits between the conv/pool delay chains and the downstream layer loader.

Parameters:
- SIG_DATA_WIDTH, 16, data word width in bits.
- DEPTH, 8, buffer entries; power of 2, ≥ 2.
- BURST_LEN, 4, words per burst; 1 ≤ BURST_LEN ≤ DEPTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Data_In  input  SIG_DATA_WIDTH  write data from delay chain.
- Data_In_Valid  input  1  write request.
- In_Ready  output  1  buffer not full; high means a write is accepted this cycle.
- Flush  input  1  one-cycle pulse requesting the buffer be drained fully.
- Data_Out  output  SIG_DATA_WIDTH  read data, always mem[rd_ptr].
- Data_Out_Valid  output  1  Data_Out holds a valid word.
- Out_Ready  input  1  consumer accepts the word.
- Burst_Active  output  1  FSM is in BURST or FLUSH.
- Count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset: the only reset is synchronous, active-high, sampled on the clk rising edge. It clears:
  - wr_ptr, rd_ptr, Count, beat counter, pending-flush flag;
  - FSM state to IDLE.
  - Outputs after reset: In_Ready=1, Data_Out_Valid=0, Burst_Active=0, Count=0.
  - Data_Out after reset: X/don't-care; memory contents are not cleared.
  - Reset asserted mid-burst aborts immediately; all buffered words are discarded.
- Write:
  - wr = Data_In_Valid && In_Ready.
  - In_Ready = (Count != DEPTH), from registered Count only.
  - A full buffer rejects writes even when a read happens the same cycle; the rejected word is dropped.
  - On wr: mem[wr_ptr] <= Data_In; wr_ptr increments modulo DEPTH (natural wrap).
- Read:
  - rd = Data_Out_Valid && Out_Ready.
  - On rd: rd_ptr increments modulo DEPTH.
- Count:
  - Count <= Count + wr - rd.
  - Simultaneous wr and rd leaves Count unchanged.
- Output valid:
  - Data_Out_Valid = (state != IDLE) && (Count != 0).
  - Data_Out is a combinational read of mem[rd_ptr].
  - Data_Out must hold stable while Data_Out_Valid=1 and Out_Ready=0.
- FSM, IDLE:
  - Flush pending and Count != 0 -> FLUSH (takes priority).
  - Else Count >= BURST_LEN -> BURST, with beats_left <= BURST_LEN.
  - Else stay in IDLE.
  - Flush pulse with Count == 0 is discarded; the pending flag is cleared.
- FSM, BURST:
  - Each rd decrements beats_left.
  - On the rd that takes beats_left from 1 to 0:
    - Flush pending and (Count - 1 + wr) != 0 -> FLUSH.
    - Else -> IDLE.
  - Flush arriving during BURST sets the pending flag; the burst is never truncated.
- FSM, FLUSH:
  - Drains until Count == 0 is observed, then -> IDLE and the pending flag clears.
  - Writes are still accepted during FLUSH and extend the drain.
  - Flush pulses received in FLUSH are ignored.
- Latency:
  - A word written at edge t is counted after t.
  - IDLE->BURST occurs at the first edge where registered Count ≥ BURST_LEN.
  - Minimum write-to-Data_Out_Valid is 1 cycle after Count reaches BURST_LEN.
  - Back-to-back bursts: one IDLE cycle between bursts.
- Burst_Active = (state == BURST || state == FLUSH).

Optional Feature:
- Macro: DELAY_FIFO_DRAIN_ERR_FLAGS_EN.
- When defined, two extra output ports are added:
  - Overflow_Err (1 bit): sticky, set when Data_In_Valid=1 while In_Ready=0.
  - Underflow_Err (1 bit): sticky, set when Out_Ready=1 while Burst_Active=1 and Count==0.
  - Both clear only on reset.
- When undefined:
  - The ports do not exist.
  - Rejected writes are silently dropped.
  - No error logic is synthesised.

Test Plan:
- Reset then idle -> In_Ready=1, Count=0, Data_Out_Valid=0, Burst_Active=0; assert reset mid-BURST with Count=5 -> next cycle Count=0, state IDLE.
- Write 0x0001..0x0004 back-to-back, Out_Ready=1 -> Data_Out_Valid rises one cycle after Count=4; outputs 0x0001..0x0004 in order; Count returns to 0; back to IDLE.
- Write 3 words then pulse Flush -> FLUSH entered, 3 words drained, then IDLE; pulse Flush with Count=0 -> no state change.
- Fill 8 words with Out_Ready=0 -> In_Ready=0 at Count=8; 9th write 0xDEAD dropped (Overflow_Err=1 if macro defined); release Out_Ready -> burst of 4; second burst of 4 after one IDLE cycle; 0xDEAD never appears.
- Toggle Out_Ready 1,0,0,1,... during a burst -> Data_Out stable while stalled; exactly BURST_LEN transfers per burst.
- Flush pulsed on 2nd beat of a burst with 6 words buffered -> burst completes 4 beats, FSM goes directly to FLUSH, drains remaining 2, then IDLE.

Source files
------------

// File: rtl/delay_fifo_drain.sv
// Circular drain buffer: accepts a valid-qualified stream and releases it in fixed bursts or a full flush.
// Optional sticky error outputs are enabled by defining DELAY_FIFO_DRAIN_ERR_FLAGS_EN.
module delay_fifo_drain #(
  parameter int SIG_DATA_WIDTH = 16,
  parameter int DEPTH          = 8,
  parameter int BURST_LEN      = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [SIG_DATA_WIDTH-1:0]       Data_In,
  input  logic                            Data_In_Valid,
  output logic                            In_Ready,
  input  logic                            Flush,
  output logic [SIG_DATA_WIDTH-1:0]       Data_Out,
  output logic                            Data_Out_Valid,
  input  logic                            Out_Ready,
  output logic                            Burst_Active,
`ifdef DELAY_FIFO_DRAIN_ERR_FLAGS_EN
  output logic                            Overflow_Err,
  output logic                            Underflow_Err,
`endif
  output logic [$clog2(DEPTH+1)-1:0]      Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int BW = $clog2(BURST_LEN+1);

  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, FLUSH = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [BW-1:0]       beats_q, beats_d;
  logic                flush_pend_q, flush_pend_d;
  logic                wr, rd, flush_req;

  logic [SIG_DATA_WIDTH-1:0] mem [DEPTH];

  assign wr        = Data_In_Valid && In_Ready;
  assign rd        = Data_Out_Valid && Out_Ready;
  assign flush_req = Flush || flush_pend_q;
  assign Data_Out  = mem[rd_ptr_q];
  assign Count     = count_q;

  // Storage is never cleared; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr_q] <= Data_In;
  end

  always_comb begin
    wr_ptr_d = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({wr, rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      beats_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      beats_q      <= beats_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    beats_d      = beats_q;
    flush_pend_d = flush_pend_q;
    case (state_q)
      IDLE: begin
        // A flush request with nothing buffered is simply dropped.
        flush_pend_d = 1'b0;
        if (flush_req && (count_q != '0)) begin
          state_d = FLUSH;
        end else if (count_q >= CW'(BURST_LEN)) begin
          state_d = BURST;
          beats_d = BW'(BURST_LEN);
        end
      end
      BURST: begin
        if (Flush) flush_pend_d = 1'b1;
        if (rd) begin
          beats_d = beats_q - BW'(1);
          // Bursts always run to completion; a queued flush takes over afterwards.
          if (beats_q == BW'(1)) begin
            flush_pend_d = 1'b0;
            if (flush_req && (count_d != '0)) state_d = FLUSH;
            else                              state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        flush_pend_d = 1'b0;
        if (count_q == '0) state_d = IDLE;
      end
      default: begin
        state_d      = IDLE;
        flush_pend_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    In_Ready       = (count_q != CW'(DEPTH));
    Burst_Active   = (state_q == BURST) || (state_q == FLUSH);
    Data_Out_Valid = (state_q != IDLE) && (count_q != '0);
  end

`ifdef DELAY_FIFO_DRAIN_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  || (Data_In_Valid && !In_Ready);
    underflow_d = underflow_q || (Out_Ready && Burst_Active && (count_q == '0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign Overflow_Err  = overflow_q;
  assign Underflow_Err = underflow_q;
`endif

endmodule

// File: tb/tb_delay_fifo_drain.sv
// Directed bench for delay_fifo_drain: a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_delay_fifo_drain;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] Data_In;
  logic        Data_In_Valid;
  logic        In_Ready;
  logic        Flush;
  logic [15:0] Data_Out;
  logic        Data_Out_Valid;
  logic        Out_Ready;
  logic        Burst_Active;
  logic [3:0]  Count;
`ifdef DELAY_FIFO_DRAIN_ERR_FLAGS_EN
  logic        Overflow_Err;
  logic        Underflow_Err;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  delay_fifo_drain #(.SIG_DATA_WIDTH(16), .DEPTH(8), .BURST_LEN(4)) dut (
    .clk(clk),
    .reset(reset),
    .Data_In(Data_In),
    .Data_In_Valid(Data_In_Valid),
    .In_Ready(In_Ready),
    .Flush(Flush),
    .Data_Out(Data_Out),
    .Data_Out_Valid(Data_Out_Valid),
    .Out_Ready(Out_Ready),
    .Burst_Active(Burst_Active),
`ifdef DELAY_FIFO_DRAIN_ERR_FLAGS_EN
    .Overflow_Err(Overflow_Err),
    .Underflow_Err(Underflow_Err),
`endif
    .Count(Count)
  );

  typedef struct {
    logic        din_v;
    logic [15:0] din;
    logic        flush;
    logic        ordy;
    logic        e_ir;
    logic        e_dv;
    logic [15:0] e_dout;
    logic        e_ba;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input logic v, input logic [15:0] d, input logic f, input logic o,
                              input logic ir, input logic dv, input logic [15:0] dout,
                              input logic ba, input logic [3:0] cnt);
    vec_t r;
    r.din_v = v;  r.din = d;   r.flush = f;     r.ordy = o;
    r.e_ir = ir;  r.e_dv = dv; r.e_dout = dout; r.e_ba = ba; r.e_cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic r, input logic v, input logic [15:0] d, input logic f, input logic o);
    @(negedge clk);
    reset = r; Data_In_Valid = v; Data_In = d; Flush = f; Out_Ready = o;
    #1;
  endtask

  task automatic write_words(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, base + 16'(i), 1'b0, 1'b0);
  endtask

  logic [3:0]  pat;
  int          xfers;
  logic        prev_stall;
  logic [15:0] prev_dout;

  initial begin
    reset = 1'b1; Data_In_Valid = 1'b0; Data_In = '0; Flush = 1'b0; Out_Ready = 1'b0;

    // Burst of 0x0001..0x0004, then a three-word flush, then a flush with an empty buffer.
    tbl[0]  = mk(1, 16'h0001, 0, 1,  1, 0, 16'h0000, 0, 4'd0);
    tbl[1]  = mk(1, 16'h0002, 0, 1,  1, 0, 16'h0000, 0, 4'd1);
    tbl[2]  = mk(1, 16'h0003, 0, 1,  1, 0, 16'h0000, 0, 4'd2);
    tbl[3]  = mk(1, 16'h0004, 0, 1,  1, 0, 16'h0000, 0, 4'd3);
    tbl[4]  = mk(0, 16'h0000, 0, 1,  1, 0, 16'h0000, 0, 4'd4);
    tbl[5]  = mk(0, 16'h0000, 0, 1,  1, 1, 16'h0001, 1, 4'd4);
    tbl[6]  = mk(0, 16'h0000, 0, 1,  1, 1, 16'h0002, 1, 4'd3);
    tbl[7]  = mk(0, 16'h0000, 0, 1,  1, 1, 16'h0003, 1, 4'd2);
    tbl[8]  = mk(0, 16'h0000, 0, 1,  1, 1, 16'h0004, 1, 4'd1);
    tbl[9]  = mk(1, 16'h0011, 0, 1,  1, 0, 16'h0000, 0, 4'd0);
    tbl[10] = mk(1, 16'h0012, 0, 1,  1, 0, 16'h0000, 0, 4'd1);
    tbl[11] = mk(1, 16'h0013, 0, 1,  1, 0, 16'h0000, 0, 4'd2);
    tbl[12] = mk(0, 16'h0000, 1, 1,  1, 0, 16'h0000, 0, 4'd3);
    tbl[13] = mk(0, 16'h0000, 0, 1,  1, 1, 16'h0011, 1, 4'd3);
    tbl[14] = mk(0, 16'h0000, 0, 1,  1, 1, 16'h0012, 1, 4'd2);
    tbl[15] = mk(0, 16'h0000, 0, 1,  1, 1, 16'h0013, 1, 4'd1);
    tbl[16] = mk(0, 16'h0000, 0, 1,  1, 0, 16'h0000, 1, 4'd0);
    tbl[17] = mk(0, 16'h0000, 1, 1,  1, 0, 16'h0000, 0, 4'd0);
    tbl[18] = mk(0, 16'h0000, 0, 1,  1, 0, 16'h0000, 0, 4'd0);
    tbl[19] = mk(0, 16'h0000, 0, 1,  1, 0, 16'h0000, 0, 4'd0);

    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      drive(1'b0, tbl[i].din_v, tbl[i].din, tbl[i].flush, tbl[i].ordy);
      $display("[TB] row %0d: cnt=%0d dv=%0b ba=%0b ir=%0b dout=0x%04h", i, Count, Data_Out_Valid,
               Burst_Active, In_Ready, Data_Out);
      chk($sformatf("row%0d In_Ready", i), 32'(In_Ready), 32'(tbl[i].e_ir));
      chk($sformatf("row%0d Data_Out_Valid", i), 32'(Data_Out_Valid), 32'(tbl[i].e_dv));
      chk($sformatf("row%0d Burst_Active", i), 32'(Burst_Active), 32'(tbl[i].e_ba));
      chk($sformatf("row%0d Count", i), 32'(Count), 32'(tbl[i].e_cnt));
      if (tbl[i].e_dv) chk($sformatf("row%0d Data_Out", i), 32'(Data_Out), 32'(tbl[i].e_dout));
    end
`ifdef DELAY_FIFO_DRAIN_ERR_FLAGS_EN
    chk("after table Overflow_Err", 32'(Overflow_Err), 32'd0);
    chk("after table Underflow_Err", 32'(Underflow_Err), 32'd1);
`endif

    // Fill to full with the consumer stalled, try a ninth write, then drain two bursts.
    write_words(16'h0100, 8);
    drive(1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b0);
    $display("[TB] full: cnt=%0d ir=%0b", Count, In_Ready);
    chk("full In_Ready", 32'(In_Ready), 32'd0);
    chk("full Count", 32'(Count), 32'd8);
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      $display("[TB] drain %0d: cnt=%0d dv=%0b ba=%0b dout=0x%04h", k, Count, Data_Out_Valid,
               Burst_Active, Data_Out);
      if (k == 4 || k == 9) begin
        chk($sformatf("drain%0d Burst_Active", k), 32'(Burst_Active), 32'd0);
        chk($sformatf("drain%0d Data_Out_Valid", k), 32'(Data_Out_Valid), 32'd0);
        chk($sformatf("drain%0d Count", k), 32'(Count), (k == 4) ? 32'd4 : 32'd0);
      end else begin
        chk($sformatf("drain%0d Burst_Active", k), 32'(Burst_Active), 32'd1);
        chk($sformatf("drain%0d Data_Out_Valid", k), 32'(Data_Out_Valid), 32'd1);
        chk($sformatf("drain%0d Data_Out", k), 32'(Data_Out),
            (k < 4) ? 32'h100 + 32'(k) : 32'h104 + 32'(k - 5));
        chk($sformatf("drain%0d Count", k), 32'(Count), (k < 4) ? 32'(8 - k) : 32'(4 - (k - 5)));
      end
    end
`ifdef DELAY_FIFO_DRAIN_ERR_FLAGS_EN
    chk("overflow Overflow_Err", 32'(Overflow_Err), 32'd1);
`endif

    // Stalling consumer (1,0,0,1 pattern): word must hold while stalled, exactly four beats per burst.
    write_words(16'h0200, 5);
    pat = 4'b1001;
    xfers = 0;
    prev_stall = 1'b0;
    prev_dout = '0;
    for (int k = 0; k < 30 && xfers < 4; k++) begin
      drive(1'b0, 1'b0, 16'h0, 1'b0, pat[3 - (k % 4)]);
      $display("[TB] stall %0d: ordy=%0b dv=%0b dout=0x%04h", k, Out_Ready, Data_Out_Valid, Data_Out);
      chk("stall Burst_Active", 32'(Burst_Active), 32'd1);
      chk("stall Data_Out_Valid", 32'(Data_Out_Valid), 32'd1);
      chk("stall Data_Out", 32'(Data_Out), 32'h200 + 32'(xfers));
      if (prev_stall) chk("stall hold Data_Out", 32'(Data_Out), 32'(prev_dout));
      prev_stall = !Out_Ready;
      prev_dout  = Data_Out;
      if (Out_Ready && Data_Out_Valid) xfers++;
    end
    chk("stall transfers", 32'(xfers), 32'd4);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("post-burst Burst_Active", 32'(Burst_Active), 32'd0);
    chk("post-burst Count", 32'(Count), 32'd1);
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("leftover Burst_Active", 32'(Burst_Active), 32'd1);
    chk("leftover Data_Out", 32'(Data_Out), 32'h204);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("leftover Count", 32'(Count), 32'd0);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("leftover idle", 32'(Burst_Active), 32'd0);

    // Flush arrives on the second beat of a burst with six words buffered.
    write_words(16'h0300, 6);
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 16'h0, (k == 1), 1'b1);
      $display("[TB] midflush %0d: cnt=%0d dv=%0b ba=%0b dout=0x%04h", k, Count, Data_Out_Valid,
               Burst_Active, Data_Out);
      chk($sformatf("midflush%0d Burst_Active", k), 32'(Burst_Active), (k < 7) ? 32'd1 : 32'd0);
      chk($sformatf("midflush%0d Count", k), 32'(Count), (k < 6) ? 32'(6 - k) : 32'd0);
      chk($sformatf("midflush%0d Data_Out_Valid", k), 32'(Data_Out_Valid), (k < 6) ? 32'd1 : 32'd0);
      if (k < 6) chk($sformatf("midflush%0d Data_Out", k), 32'(Data_Out), 32'h300 + 32'(k));
    end

    // Reset in the middle of a burst with five words buffered.
    write_words(16'h0400, 5);
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("pre-reset Burst_Active", 32'(Burst_Active), 32'd1);
    chk("pre-reset Count", 32'(Count), 32'd5);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    $display("[TB] post-reset: cnt=%0d dv=%0b ba=%0b ir=%0b", Count, Data_Out_Valid, Burst_Active, In_Ready);
    chk("post-reset Count", 32'(Count), 32'd0);
    chk("post-reset Burst_Active", 32'(Burst_Active), 32'd0);
    chk("post-reset In_Ready", 32'(In_Ready), 32'd1);
    chk("post-reset Data_Out_Valid", 32'(Data_Out_Valid), 32'd0);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("post-reset stays idle", 32'(Burst_Active), 32'd0);
`ifdef DELAY_FIFO_DRAIN_ERR_FLAGS_EN
    chk("post-reset Overflow_Err", 32'(Overflow_Err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
